mem_stage_ext: RTL and testbench

- Next-generation MEM pipeline stage of the MIPS datapath. Sits between the EX/MEM and MEM/WB boundaries.
- Adds sub-word loads/stores with sign/zero extension, misalignment detection, and BEQ/BNE branch resolution.
- Adds a parametrised multi-cycle memory latency with a stall handshake, and a resettable MEM/WB register with bubble insertion.

---
 rtl/mem_stage_ext.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage_ext.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ext.sv
// MEM pipeline stage: sub-word load/store with extension, misalignment detection,
// branch resolution, multi-cycle memory latency with stall, and the MEM/WB register.
module mem_stage_ext #(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int MEM_BUS_WIDTH = 7,
  parameter int WB_BUS_WIDTH  = 2,
  parameter int MEM_DEPTH     = 256,
  parameter int MEM_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_zero_flag,
  input  logic [MEM_BUS_WIDTH-1:0] mem_bus_in,
  input  logic [WB_BUS_WIDTH-1:0]  wb_bus_in,
  input  logic [ADDR_BITS-1:0]     addr_mem,
  input  logic [DATA_WIDTH-1:0]    store_data,
  input  logic [DATA_WIDTH-1:0]    alu_data_in,
  input  logic [REG_ADDR_BITS-1:0] reg_w_addr_in,
  output logic                     branch,
  output logic                     stall,
  output logic [DATA_WIDTH-1:0]    load_data_out,
  output logic [WB_BUS_WIDTH-1:0]  wb_bus_out,
  output logic [REG_ADDR_BITS-1:0] reg_w_addr_out,
  output logic [DATA_WIDTH-1:0]    alu_data_out,
  output logic                     misaligned_out
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [DATA_WIDTH-1:0]    r_mem [0:MEM_DEPTH-1];
  logic [0:0]               r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0]    r_load_data;
  logic [WB_BUS_WIDTH-1:0]  r_wb_bus;
  logic [REG_ADDR_BITS-1:0] r_reg_w_addr;
  logic [DATA_WIDTH-1:0]    r_alu_data;
  logic                     r_misaligned;

  logic                  w_write, w_read, w_acc, w_uns, w_is_half, w_is_word, w_mis;
  logic [1:0]            w_size;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_word, w_load, w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [3:0]            w_be;
  logic                  w_stall, w_commit;
  logic [0:0]            w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_unused_addr;

  assign w_write   = mem_bus_in[0];
  assign w_read    = mem_bus_in[1];
  assign w_size    = mem_bus_in[5:4];
  assign w_uns     = mem_bus_in[6];
  assign w_acc     = w_write | w_read;
  assign w_is_half = (w_size == 2'b01);
  assign w_is_word = w_size[1];
  assign w_mis     = w_acc & ((w_is_half & addr_mem[0]) |
                              (w_is_word & (addr_mem[1:0] != 2'b00)));
  // Upper address bits are deliberately ignored so the memory wraps around.
  assign w_idx         = addr_mem[IDX_W+1:2];
  assign w_unused_addr = ^addr_mem[ADDR_BITS-1:IDX_W+2];
  assign w_rd_word     = r_mem[w_idx];

  assign branch = mem_bus_in[2] & (alu_zero_flag ^ mem_bus_in[3]);

  // Lane extraction and sign/zero extension of the read word.
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    w_load = {DATA_WIDTH{1'b0}};
    case (addr_mem[1:0])
      2'b00:   w_byte = w_rd_word[7:0];
      2'b01:   w_byte = w_rd_word[15:8];
      2'b10:   w_byte = w_rd_word[23:16];
      2'b11:   w_byte = w_rd_word[31:24];
      default: w_byte = 8'h00;
    endcase
    if (addr_mem[1]) begin
      w_half = w_rd_word[31:16];
    end else begin
      w_half = w_rd_word[15:0];
    end
    case (w_size)
      2'b00:   w_load = w_uns ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = w_uns ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = w_rd_word;
    endcase
  end

  // Byte enables and lane-replicated write data.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = store_data;
    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << addr_mem[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_be    = addr_mem[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  // Latency FSM: stall is asserted on every cycle of an access except the last.
  always_comb begin
    w_stall     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_acc && !w_mis && (MEM_LATENCY > 1)) begin
          w_stall     = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_INIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt != {CNT_W{1'b0}}) begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset forces stall low and blocks any pending commit.
  assign stall    = w_stall & rst_n;
  assign w_commit = rst_n & w_write & ~w_mis & ~w_stall;

  // Data memory, byte-lane writes, no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_commit && w_be[i]) begin
        r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // FSM state and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // MEM/WB register: bubble while stalled, squash write-back on misalignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_data  <= {DATA_WIDTH{1'b0}};
      r_wb_bus     <= {WB_BUS_WIDTH{1'b0}};
      r_reg_w_addr <= {REG_ADDR_BITS{1'b0}};
      r_alu_data   <= {DATA_WIDTH{1'b0}};
      r_misaligned <= 1'b0;
    end else if (w_stall) begin
      r_wb_bus <= {WB_BUS_WIDTH{1'b0}};
    end else begin
      r_load_data  <= w_load;
      r_wb_bus     <= w_mis ? {WB_BUS_WIDTH{1'b0}} : wb_bus_in;
      r_reg_w_addr <= reg_w_addr_in;
      r_alu_data   <= alu_data_in;
      r_misaligned <= w_mis;
    end
  end

  assign load_data_out  = r_load_data;
  assign wb_bus_out     = r_wb_bus;
  assign reg_w_addr_out = r_reg_w_addr;
  assign alu_data_out   = r_alu_data;
  assign misaligned_out = r_misaligned;

endmodule

// File: tb/tb_mem_stage_ext.sv
// Bench for mem_stage_ext: a single-cycle instance checked against a byte-array
// memory model, and a 3-cycle-latency instance for the stall handshake.
module tb_mem_stage_ext;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0]  a_bus, b_bus;
  logic [1:0]  a_wb, b_wb, a_wbo, b_wbo;
  logic [31:0] a_addr, a_sd, a_alu, a_ld, a_aluo;
  logic [31:0] b_addr, b_sd, b_alu, b_ld, b_aluo;
  logic [4:0]  a_rd, a_rdo, b_rd, b_rdo;
  logic        a_zero, a_branch, a_stall, a_mis;
  logic        b_zero, b_branch, b_stall, b_mis;

  mem_stage_ext #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .alu_zero_flag(a_zero), .mem_bus_in(a_bus),
    .wb_bus_in(a_wb), .addr_mem(a_addr), .store_data(a_sd), .alu_data_in(a_alu),
    .reg_w_addr_in(a_rd), .branch(a_branch), .stall(a_stall), .load_data_out(a_ld),
    .wb_bus_out(a_wbo), .reg_w_addr_out(a_rdo), .alu_data_out(a_aluo),
    .misaligned_out(a_mis));

  mem_stage_ext #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .alu_zero_flag(b_zero), .mem_bus_in(b_bus),
    .wb_bus_in(b_wb), .addr_mem(b_addr), .store_data(b_sd), .alu_data_in(b_alu),
    .reg_w_addr_in(b_rd), .branch(b_branch), .stall(b_stall), .load_data_out(b_ld),
    .wb_bus_out(b_wbo), .reg_w_addr_out(b_rdo), .alu_data_out(b_aluo),
    .misaligned_out(b_mis));

  // Reference memory: 1 KiB as plain bytes, little-endian.
  logic [7:0] mm [0:1023];

  function automatic logic model_mis(input logic [6:0] bus, input logic [31:0] addr);
    if (bus[5:4] == 2'b01) return addr[0];
    if (bus[5])            return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [6:0] bus, input logic [31:0] addr);
    int b;
    logic [7:0]  x;
    logic [15:0] h;
    b = int'(addr % 1024);
    if (bus[5:4] == 2'b00) begin
      x = mm[b];
      return (bus[6] || !x[7]) ? {24'h0, x} : {24'hFFFFFF, x};
    end
    if (bus[5:4] == 2'b01) begin
      b = b - (b % 2);
      h = {mm[b+1], mm[b]};
      return (bus[6] || !h[15]) ? {16'h0, h} : {16'hFFFF, h};
    end
    b = b - (b % 4);
    return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
  endfunction

  task automatic model_write(input logic [6:0] bus, input logic [31:0] addr, input logic [31:0] sd);
    int b;
    int n;
    b = int'(addr % 1024);
    n = (bus[5:4] == 2'b00) ? 1 : (bus[5:4] == 2'b01) ? 2 : 4;
    b = b - (b % n);
    for (int k = 0; k < n; k++) mm[b+k] = sd[8*k +: 8];
  endtask

  // One transaction on the single-cycle instance; returns model expectations.
  task automatic drive_a(input logic [6:0] bus, input logic [31:0] addr, input logic [31:0] sd,
                         output logic [31:0] e_ld, output logic [1:0] e_wb, output logic e_mis,
                         output logic [31:0] e_alu, output logic [4:0] e_rd, output logic o_stall);
    logic mis;
    @(negedge clk);
    a_bus = bus; a_addr = addr; a_sd = sd;
    a_wb = 2'($urandom_range(1, 3)); a_alu = $urandom; a_rd = 5'($urandom); a_zero = 1'($urandom);
    mis   = (bus[0] | bus[1]) && model_mis(bus, addr);
    e_mis = mis;
    e_wb  = mis ? 2'b00 : a_wb;
    e_ld  = model_load(bus, addr);
    e_alu = a_alu;
    e_rd  = a_rd;
    #1 o_stall = a_stall;
    @(posedge clk);
    if (bus[0] && !mis) model_write(bus, addr, sd);
    #1;
  endtask

  // One transaction on the latency-3 instance, holding inputs while stalled.
  task automatic drive_b(input logic [6:0] bus, input logic [31:0] addr, input logic [31:0] sd,
                         output int stalls, output logic bub_ok, output logic done,
                         output logic [1:0] wb_in);
    @(negedge clk);
    b_bus = bus; b_addr = addr; b_sd = sd;
    b_wb = 2'($urandom_range(1, 3)); b_alu = $urandom; b_rd = 5'($urandom); b_zero = 1'b0;
    wb_in = b_wb; stalls = 0; bub_ok = 1'b1; done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      #1;
      if (b_stall) begin
        stalls++;
        @(posedge clk); #1;
        if (b_wbo !== 2'b00) bub_ok = 1'b0;
        @(negedge clk);
      end else begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_bus = 7'h0; a_wb = 2'h3; a_addr = 32'h0; a_sd = 32'h0; a_alu = 32'h1; a_rd = 5'h1; a_zero = 1'b0;
    b_bus = 7'h21; b_wb = 2'h3; b_addr = 32'h20; b_sd = 32'h0; b_alu = 32'h1; b_rd = 5'h1; b_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a_ld, a_wbo, a_rdo, a_aluo, a_mis, a_stall} !== 73'h0) begin
      bad++; $display("FAIL reset_a: got %h want 0", {a_ld, a_wbo, a_rdo, a_aluo, a_mis, a_stall});
    end
    total++;
    if ({b_ld, b_wbo, b_rdo, b_aluo, b_mis, b_stall} !== 73'h0) begin
      bad++; $display("FAIL reset_b: got %h want 0", {b_ld, b_wbo, b_rdo, b_aluo, b_mis, b_stall});
    end
    @(negedge clk);
    b_bus = 7'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [31:0] e_ld, e_alu; logic [1:0] e_wb; logic e_mis, st; logic [4:0] e_rd;
    for (int i = 0; i < 256; i++) drive_a(7'h21, 32'(i * 4), 32'h0, e_ld, e_wb, e_mis, e_alu, e_rd, st);
  endtask

  task automatic test_word();
    logic [31:0] e_ld, e_alu; logic [1:0] e_wb; logic e_mis, st; logic [4:0] e_rd;
    drive_a(7'h21, 32'h10, 32'hDEADBEEF, e_ld, e_wb, e_mis, e_alu, e_rd, st);
    drive_a(7'h22, 32'h10, 32'h0, e_ld, e_wb, e_mis, e_alu, e_rd, st);
    total++;
    if (a_ld !== 32'hDEADBEEF) begin bad++; $display("FAIL word_load: got %h want DEADBEEF", a_ld); end
    total++;
    if ({a_wbo, a_rdo, a_aluo, a_mis} !== {a_wb, a_rd, a_alu, 1'b0}) begin
      bad++; $display("FAIL word_regs: got %h want %h", {a_wbo, a_rdo, a_aluo, a_mis}, {a_wb, a_rd, a_alu, 1'b0});
    end
  endtask

  task automatic test_subword();
    logic [31:0] e_ld, e_alu; logic [1:0] e_wb; logic e_mis, st; logic [4:0] e_rd;
    drive_a(7'h21, 32'h10, 32'h0, e_ld, e_wb, e_mis, e_alu, e_rd, st);
    drive_a(7'h01, 32'h13, 32'h123456AB, e_ld, e_wb, e_mis, e_alu, e_rd, st);
    drive_a(7'h02, 32'h13, 32'h0, e_ld, e_wb, e_mis, e_alu, e_rd, st);
    total++;
    if (a_ld !== 32'hFFFFFFAB) begin bad++; $display("FAIL byte_signed: got %h want FFFFFFAB", a_ld); end
    drive_a(7'h42, 32'h13, 32'h0, e_ld, e_wb, e_mis, e_alu, e_rd, st);
    total++;
    if (a_ld !== 32'h000000AB) begin bad++; $display("FAIL byte_unsigned: got %h want 000000AB", a_ld); end
    drive_a(7'h12, 32'h12, 32'h0, e_ld, e_wb, e_mis, e_alu, e_rd, st);
    total++;
    if (a_ld !== 32'hFFFFAB00) begin bad++; $display("FAIL half_signed: got %h want FFFFAB00", a_ld); end
    drive_a(7'h22, 32'h10, 32'h0, e_ld, e_wb, e_mis, e_alu, e_rd, st);
    total++;
    if (a_ld !== 32'hAB000000) begin bad++; $display("FAIL byte_word_view: got %h want AB000000", a_ld); end
  endtask

  task automatic test_misaligned();
    logic [31:0] e_ld, e_alu; logic [1:0] e_wb; logic e_mis, st; logic [4:0] e_rd;
    drive_a(7'h11, 32'h11, 32'h5555, e_ld, e_wb, e_mis, e_alu, e_rd, st);
    total++;
    if ({a_mis, a_wbo, st} !== 4'b1000) begin
      bad++; $display("FAIL misaligned_half: got mis/wb/stall=%b want 1000", {a_mis, a_wbo, st});
    end
    drive_a(7'h22, 32'h10, 32'h0, e_ld, e_wb, e_mis, e_alu, e_rd, st);
    total++;
    if ({a_ld, a_mis} !== {32'hAB000000, 1'b0}) begin
      bad++; $display("FAIL misaligned_nowrite: got %h/%b want AB000000/0", a_ld, a_mis);
    end
    drive_a(7'h22, 32'h12, 32'h0, e_ld, e_wb, e_mis, e_alu, e_rd, st);
    total++;
    if ({a_mis, a_wbo} !== 3'b100) begin bad++; $display("FAIL misaligned_word: got %b want 100", {a_mis, a_wbo}); end
  endtask

  task automatic test_branch();
    logic [6:0] bus_t [5] = '{7'h04, 7'h0C, 7'h0C, 7'h04, 7'h00};
    logic       zf_t  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       exp_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_bus = bus_t[i]; a_zero = zf_t[i];
      #1;
      total++;
      if (a_branch !== exp_t[i]) begin
        bad++; $display("FAIL branch_%0d: got %b want %b", i, a_branch, exp_t[i]);
      end
    end
    @(negedge clk);
    a_bus = 7'h0;
  endtask

  task automatic test_random();
    logic [31:0] e_ld, e_alu; logic [1:0] e_wb; logic e_mis, st; logic [4:0] e_rd;
    for (int i = 0; i < 400; i++) begin
      drive_a(7'($urandom), $urandom, $urandom, e_ld, e_wb, e_mis, e_alu, e_rd, st);
      total++;
      if ({a_ld, a_wbo, a_mis, a_aluo, a_rdo, st} !== {e_ld, e_wb, e_mis, e_alu, e_rd, 1'b0}) begin
        bad++;
        $display("FAIL random_%0d: got ld=%h wb=%h mis=%b alu=%h rd=%h stall=%b want ld=%h wb=%h mis=%b alu=%h rd=%h stall=0",
                 i, a_ld, a_wbo, a_mis, a_aluo, a_rdo, st, e_ld, e_wb, e_mis, e_alu, e_rd);
      end
    end
  endtask

  task automatic test_latency();
    int n; logic ok, done; logic [1:0] wbi;
    drive_b(7'h21, 32'h20, 32'h0, n, ok, done, wbi);
    drive_b(7'h21, 32'h20, 32'h12345678, n, ok, done, wbi);
    total++;
    if (!done || n != 2 || !ok) begin
      bad++; $display("FAIL lat_store: got stalls=%0d bubbles_ok=%b done=%b want 2/1/1", n, ok, done);
    end
    total++;
    if (b_wbo !== wbi) begin bad++; $display("FAIL lat_store_wb: got %h want %h", b_wbo, wbi); end
    drive_b(7'h22, 32'h20, 32'h0, n, ok, done, wbi);
    total++;
    if (!done || n != 2 || b_ld !== 32'h12345678) begin
      bad++; $display("FAIL lat_load: got stalls=%0d ld=%h want 2/12345678", n, b_ld);
    end
    drive_b(7'h00, 32'h20, 32'h0, n, ok, done, wbi);
    total++;
    if (!done || n != 0) begin bad++; $display("FAIL lat_noaccess: got stalls=%0d want 0", n); end
    drive_b(7'h22, 32'h21, 32'h0, n, ok, done, wbi);
    total++;
    if (!done || n != 0 || b_mis !== 1'b1) begin
      bad++; $display("FAIL lat_misaligned: got stalls=%0d mis=%b want 0/1", n, b_mis);
    end
  endtask

  task automatic test_reset_wait();
    int n; logic ok, done; logic [1:0] wbi;
    @(negedge clk);
    b_bus = 7'h21; b_addr = 32'h20; b_sd = 32'hCAFEF00D; b_wb = 2'h3;
    #1;
    total++;
    if (b_stall !== 1'b1) begin bad++; $display("FAIL rstwait_enter: got stall=%b want 1", b_stall); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({b_ld, b_wbo, b_rdo, b_aluo, b_mis, b_stall} !== 73'h0) begin
      bad++; $display("FAIL rstwait_outputs: got %h want 0", {b_ld, b_wbo, b_rdo, b_aluo, b_mis, b_stall});
    end
    b_bus = 7'h0; a_bus = 7'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_b(7'h22, 32'h20, 32'h0, n, ok, done, wbi);
    total++;
    if (!done || b_ld !== 32'h12345678) begin
      bad++; $display("FAIL rstwait_mem: got ld=%h want 12345678", b_ld);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_word();
    test_subword();
    test_misaligned();
    test_branch();
    test_random();
    test_latency();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
